// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RISC-V fields plus a signed immediate
// into a 32-bit instruction word, range-checks the immediate and writes good
// words to instruction memory at sequential word addresses.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  full
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_ERR} state_t;

  state_t state_q, state_d;

  logic [6:0]          op_q, f7_q;
  logic [4:0]          rd_q, rs1_q, rs2_q;
  logic [2:0]          f3_q;
  logic signed [31:0]  imm_q;
  logic [31:0]         wdata_q;
  logic [1:0]          err_q;
  logic [ADDR_WIDTH:0] cnt_q;

  logic [31:0] enc_word;
  logic [1:0]  enc_err;
  logic        accept;

  assign in_ready  = (state_q == S_IDLE) & ~full & ~flush;
  assign accept    = in_valid & in_ready;
  assign mem_we    = (state_q == S_WRITE);
  assign err_valid = (state_q == S_ERR);
  assign mem_wdata = wdata_q;
  assign err_code  = err_q;
  assign wr_count  = cnt_q;
  assign mem_addr  = cnt_q[ADDR_WIDTH-1:0];
  assign full      = cnt_q[ADDR_WIDTH];

  // Instruction packing and immediate checks on the captured request.
  always_comb begin
    enc_word = '0;
    enc_err  = 2'd0;
    unique case (op_q)
      7'b0110011: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      7'b0000011, 7'b0010011, 7'b1100111: begin
        if (op_q == 7'b0010011 && (f3_q == 3'b001 || f3_q == 3'b101)) begin
          enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
          if (imm_q < 0 || imm_q > 32'sd31) enc_err = 2'd2;
        end else begin
          enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
          if (imm_q < -32'sd2048 || imm_q > 32'sd2047) enc_err = 2'd2;
        end
      end
      7'b0100011: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        if (imm_q < -32'sd2048 || imm_q > 32'sd2047) enc_err = 2'd2;
      end
      7'b1100011: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        if (imm_q[0]) enc_err = 2'd3;
        else if (imm_q < -32'sd4096 || imm_q > 32'sd4094) enc_err = 2'd2;
      end
      7'b1101111: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        if (imm_q[0]) enc_err = 2'd3;
        else if (imm_q < -32'sd1048576 || imm_q > 32'sd1048574) enc_err = 2'd2;
      end
      default: enc_err = 2'd1;
    endcase
  end

  // Next-state logic: IDLE -> ENC -> WRITE/ERR -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ENC;
      S_ENC:   state_d = (enc_err == 2'd0) ? S_WRITE : S_ERR;
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; flush aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (!reset_n)   state_q <= S_IDLE;
    else if (flush) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Request capture, encode result registers and write counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q <= '0; f7_q <= '0; rd_q <= '0; rs1_q <= '0; rs2_q <= '0;
      f3_q <= '0; imm_q <= '0; wdata_q <= '0; err_q <= '0; cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q <= in_opcode; f7_q <= in_funct7; rd_q <= in_rd;
        rs1_q <= in_rs1; rs2_q <= in_rs2; f3_q <= in_funct3;
        imm_q <= in_imm;
      end
      if (state_q == S_ENC) begin
        err_q <= enc_err;
        if (enc_err == 2'd0) wdata_q <= enc_word;
      end
      if (state_q == S_WRITE) cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the driver pushes the expected
// write/error for each accepted request, a monitor pops and compares.
module tb_instr_encoder_loader;
  localparam int AW = 2;
  localparam int CAP = 1 << AW;

  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, in_ready;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic mem_we, err_valid, full;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0] err_code;
  logic [AW:0] wr_count;

  instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_valid(err_valid),
    .err_code(err_code), .wr_count(wr_count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int addr; logic [31:0] word; } exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  int model_cnt = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: returns {code, word} from plain arithmetic on the fields.
  function automatic logic [33:0] model(int op, int rd, int rs1, int rs2,
                                        int f3, int f7, int imm);
    int unsigned u, w;
    int lo, hi, code;
    bit shift;
    u = imm; w = 0; code = 0;
    shift = (op == 'h13) && (f3 == 1 || f3 == 5);
    lo = -2048; hi = 2047;
    if (op == 'h33) begin
      w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      lo = -(2**30); hi = 2**30;
      if (imm < lo || imm > hi) begin lo = imm; hi = imm; end
    end else if (shift) begin
      w = f7 * 2**25 + (u % 32) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      lo = 0; hi = 31;
    end else if (op == 'h03 || op == 'h13 || op == 'h67) begin
      w = (u % 4096) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
    end else if (op == 'h23) begin
      w = ((u / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
          + (u % 32) * 2**7 + op;
    end else if (op == 'h63) begin
      w = ((u / 4096) % 2) * 2**31 + ((u / 32) % 64) * 2**25 + rs2 * 2**20
          + rs1 * 2**15 + f3 * 2**12 + ((u / 2) % 16) * 2**8
          + ((u / 2048) % 2) * 2**7 + op;
      lo = -4096; hi = 4094;
      if (u % 2 == 1) code = 3;
    end else if (op == 'h6F) begin
      w = ((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21
          + ((u / 2048) % 2) * 2**20 + ((u / 4096) % 256) * 2**12 + rd * 2**7 + op;
      lo = -1048576; hi = 1048574;
      if (u % 2 == 1) code = 3;
    end else code = 1;
    if (code == 0 && (imm < lo || imm > hi)) code = 2;
    return {code[1:0], w};
  endfunction

  // Monitor: every write strobe or error pulse must match the queue head.
  always @(negedge clk) begin
    if (mem_we === 1'b1 || err_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got we=%b err=%b expected none", mem_we, err_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.code == 0) begin
          chk("mem_we", {31'b0, mem_we}, 32'd1);
          chk("err_valid_on_write", {31'b0, err_valid}, 32'd0);
          chk("mem_addr", {30'b0, mem_addr}, e.addr);
          chk("mem_wdata", mem_wdata, e.word);
        end else begin
          chk("err_valid", {31'b0, err_valid}, 32'd1);
          chk("we_on_error", {31'b0, mem_we}, 32'd0);
          chk("err_code", {30'b0, err_code}, e.code);
        end
      end
    end
  end

  task automatic drive(int op, int rd, int rs1, int rs2, int f3, int f7, int imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(int op, int rd, int rs1, int rs2, int f3, int f7, int imm,
                      int code, logic [31:0] word);
    exp_t e;
    @(negedge clk);
    drive(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1;
    #1;
    if (model_cnt == CAP) begin
      chk("in_ready_full", {31'b0, in_ready}, 32'd0);
      chk("full", {31'b0, full}, 32'd1);
      repeat (2) @(negedge clk);
      chk("in_ready_full_held", {31'b0, in_ready}, 32'd0);
      in_valid = 0;
      repeat (2) @(negedge clk);
      return;
    end
    chk("in_ready", {31'b0, in_ready}, 32'd1);
    e.code = code; e.addr = model_cnt; e.word = word;
    sb.push_back(e);
    if (code == 0) model_cnt++;
    @(posedge clk);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("output_seen", sb.size(), 0);
    sb.delete();
    chk("wr_count", {29'b0, wr_count}, model_cnt);
    chk("full_flag", {31'b0, full}, (model_cnt == CAP) ? 1 : 0);
  endtask

  task automatic send_m(int op, int rd, int rs1, int rs2, int f3, int f7, int imm);
    logic [33:0] r;
    r = model(op, rd, rs1, rs2, f3, f7, imm);
    send(op, rd, rs1, rs2, f3, f7, imm, int'(r[33:32]), r[31:0]);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0; model_cnt = 0;
    #1;
    chk("flush_wr_count", {29'b0, wr_count}, 0);
    chk("flush_full", {31'b0, full}, 0);
  endtask

  initial begin
    int ops[8] = '{'h33, 'h03, 'h13, 'h67, 'h23, 'h63, 'h6F, 'h7F};
    int imms[16] = '{0, 5, -4, 31, 32, 2047, 2048, -2048, -2049, 4094, 4095,
                     -4096, -4098, 1048574, -1048576, 1048576};
    repeat (2) @(negedge clk);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_err_valid", {31'b0, err_valid}, 0);
    chk("rst_wr_count", {29'b0, wr_count}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err_code", {30'b0, err_code}, 0);
    reset_n = 1;

    send('h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093);
    do_flush();
    send('h23, 0, 1, 2, 2, 0, -4, 0, 32'hFE20AE23);
    send('h63, 0, 1, 2, 0, 0, 8, 0, 32'h00208463);
    send('h6F, 0, 0, 0, 0, 0, -4, 0, 32'hFFDFF06F);
    send('h63, 0, 1, 2, 0, 0, 7, 3, 0);
    send('h13, 1, 0, 0, 0, 0, 2048, 2, 0);
    send('h7F, 1, 0, 0, 0, 0, 0, 1, 0);
    send('h13, 2, 0, 0, 0, 0, -1, 0, 32'hFFF00113);
    send('h13, 2, 0, 0, 0, 0, 1, 0, 0);  // full: must be refused
    do_flush();
    send('h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093);

    // Flush during ENC: request vanishes.
    @(negedge clk); drive('h13, 3, 0, 0, 0, 0, 1); in_valid = 1;
    @(negedge clk); in_valid = 0; flush = 1;
    @(negedge clk); flush = 0; model_cnt = 0; #1;
    chk("flush_enc_ready", {31'b0, in_ready}, 1);
    repeat (3) @(negedge clk);
    chk("flush_enc_count", {29'b0, wr_count}, 0);

    // Flush together with in_valid in IDLE: not accepted.
    @(negedge clk); in_valid = 1; flush = 1; #1;
    chk("flush_valid_ready", {31'b0, in_ready}, 0);
    @(negedge clk); in_valid = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk("flush_valid_count", {29'b0, wr_count}, 0);

    // Reset during the WRITE cycle.
    begin
      exp_t e;
      @(negedge clk); drive('h13, 1, 0, 0, 0, 0, 5); in_valid = 1;
      e.code = 0; e.addr = 0; e.word = 32'h00500093; sb.push_back(e);
      @(negedge clk); in_valid = 0;
      @(negedge clk); reset_n = 0;
      @(negedge clk); reset_n = 1; model_cnt = 0; #1;
      chk("rstw_seen", sb.size(), 0);
      sb.delete();
      chk("rstw_wr_count", {29'b0, wr_count}, 0);
      chk("rstw_wdata", mem_wdata, 0);
      chk("rstw_we", {31'b0, mem_we}, 0);
      chk("rstw_addr", {30'b0, mem_addr}, 0);
    end
    send('h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      int op, f3, imm;
      if ($urandom_range(0, 9) == 0) do_flush();
      op = ops[$urandom_range(0, 7)];
      if (op == 'h7F) op = $urandom_range(0, 127);
      f3 = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0: imm = imms[$urandom_range(0, 15)];
        1: imm = $urandom_range(0, 80) - 40;
        default: imm = $urandom;
      endcase
      send_m(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             f3, $urandom_range(0, 127), imm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
